// File: rtl/rs_syndrome_param.sv
// Streaming RS(N,K) syndrome calculator over GF(2^8): Horner evaluation of S_i = r(alpha^(FCR+i)).
// Optional build macro RS_SYN_SHORTEN_EN: accept shortened codewords (counts NSYM+1..N) without len_err.
module rs_syndrome_param #(
    parameter int         N         = 255,
    parameter int         K         = 251,
    parameter int         FCR       = 0,
    parameter logic [8:0] PRIM_POLY = 9'h11D
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   din_val,
    input  logic                   din_sop,
    input  logic                   din_eop,
    input  logic [7:0]             din,
    output logic                   syn_val,
    input  logic                   syn_rdy,
    output logic [(N-K)*8-1:0]     syn,
    output logic                   syn_zero,
    output logic                   len_err,
    output logic                   ovf,
    output logic                   busy
);
    localparam int         NSYM  = N - K;
    localparam logic [7:0] LP_N  = 8'(N);
    localparam logic [7:0] LP_MIN = 8'(NSYM + 1);

    typedef enum logic {S_IDLE, S_ACC} state_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? PRIM_POLY[7:0] : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_pow(input int e);
        logic [7:0] r;
        int         m;
        r = 8'h01;
        m = e % 255;
        for (int k = 0; k < m; k++) r = gf_mul(r, 8'h02);
        return r;
    endfunction

    state_t                 r_state;
    state_t                 w_nextState;
    logic [NSYM-1:0][7:0]   r_acc;
    logic [NSYM-1:0][7:0]   w_accNext;
    logic [NSYM-1:0][7:0]   w_horner;
    logic [NSYM-1:0][7:0]   r_syn;
    logic [7:0]             r_cnt;
    logic [7:0]             w_cntNext;
    logic                   r_synVal;
    logic                   r_synZero;
    logic                   r_lenErr;
    logic                   r_ovf;
    logic                   w_start;
    logic                   w_step;
    logic                   w_done;
    logic                   w_canLoad;
    logic                   w_lenErr;

    assign w_start   = din_val & din_sop;
    assign w_step    = din_val & ~din_sop & (r_state == S_ACC);
    assign w_done    = din_val & din_eop & (din_sop | (r_state == S_ACC));
    assign w_canLoad = ~r_synVal | syn_rdy;

    // One constant multiplier per root; the root is folded at elaboration.
    for (genvar g = 0; g < NSYM; g++) begin : g_root
        localparam logic [7:0] ROOT = gf_pow(FCR + g);
        assign w_horner[g] = gf_mul(r_acc[g], ROOT) ^ din;
    end

    always_comb begin
        w_accNext = r_acc;
        w_cntNext = r_cnt;
        if (w_start) begin
            w_accNext = {NSYM{din}};
            w_cntNext = 8'd1;
        end else if (w_step) begin
            w_accNext = w_horner;
            if (r_cnt != 8'hFF) w_cntNext = r_cnt + 8'd1;
        end
    end

`ifdef RS_SYN_SHORTEN_EN
    assign w_lenErr = (w_cntNext < LP_MIN) || (w_cntNext > LP_N);
`else
    assign w_lenErr = (w_cntNext != LP_N);
`endif

    always_comb begin
        w_nextState = r_state;
        if (din_val && din_sop && !din_eop) begin
            w_nextState = S_ACC;
        end else if (din_val && din_eop) begin
            w_nextState = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_nextState;
            r_acc   <= w_accNext;
            r_cnt   <= w_cntNext;
        end
    end

    // A completed frame is dropped only when the held set is not leaving this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_synVal  <= 1'b0;
            r_syn     <= '0;
            r_synZero <= 1'b0;
            r_lenErr  <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_ovf <= w_done & ~w_canLoad;
            if (w_done && w_canLoad) begin
                r_synVal  <= 1'b1;
                r_syn     <= w_accNext;
                r_synZero <= (w_accNext == '0);
                r_lenErr  <= w_lenErr;
            end else if (r_synVal && syn_rdy) begin
                r_synVal <= 1'b0;
            end
        end
    end

    assign syn_val  = r_synVal;
    assign syn      = r_syn;
    assign syn_zero = r_synZero;
    assign len_err  = r_lenErr;
    assign ovf      = r_ovf;
    assign busy     = (r_state == S_ACC);

endmodule

// File: tb/tb_rs_syndrome_param.sv
// Directed-vector bench for rs_syndrome_param with RS(255,251), FCR=0, poly 0x11D.
// Expected len_err follows the RS_SYN_SHORTEN_EN build macro.
module tb_rs_syndrome_param;
    localparam int NSYM = 4;

`ifdef RS_SYN_SHORTEN_EN
    localparam bit SHORT_EN = 1'b1;
`else
    localparam bit SHORT_EN = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 din_val = 1'b0;
    logic                 din_sop = 1'b0;
    logic                 din_eop = 1'b0;
    logic [7:0]           din = 8'h00;
    logic                 syn_rdy = 1'b0;
    logic                 syn_val;
    logic [NSYM*8-1:0]    syn;
    logic                 syn_zero;
    logic                 len_err;
    logic                 ovf;
    logic                 busy;

    int nVec = 0;
    int nErr = 0;

    always #5 clk = ~clk;

    rs_syndrome_param #(
        .N(255), .K(251), .FCR(0), .PRIM_POLY(9'h11D)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .din_val(din_val), .din_sop(din_sop), .din_eop(din_eop), .din(din),
        .syn_val(syn_val), .syn_rdy(syn_rdy), .syn(syn),
        .syn_zero(syn_zero), .len_err(len_err), .ovf(ovf), .busy(busy)
    );

    typedef struct {
        int          len;
        logic [7:0]  first;
        logic [7:0]  last;
        bit          gap;
        logic [31:0] expSyn;
        bit          expZero;
        bit          expLen;
    } vec_t;

    vec_t vecs[8];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic driveIdle();
        din_val = 1'b0;
        din_sop = 1'b0;
        din_eop = 1'b0;
        din     = 8'h00;
    endtask

    // Drives one frame; returns at the falling edge right after the eop edge.
    task automatic applyStimulus(input int len, input logic [7:0] first, input logic [7:0] last, input bit gap);
        for (int k = 0; k < len; k++) begin
            if (gap && k > 0) begin
                @(negedge clk);
                driveIdle();
                din = 8'hFF;
            end
            @(negedge clk);
            din_val = 1'b1;
            din_sop = (k == 0);
            din_eop = (k == len - 1);
            din     = (k == 0) ? first : ((k == len - 1) ? last : 8'h00);
        end
        @(negedge clk);
        driveIdle();
    endtask

    initial begin
        vecs[0] = '{255, 8'h00, 8'h00, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[1] = '{255, 8'h01, 8'h00, 1'b1, 32'hAD478E01, 1'b0, 1'b0};
        vecs[2] = '{255, 8'h00, 8'h5A, 1'b0, 32'h5A5A5A5A, 1'b0, 1'b0};
        vecs[3] = '{200, 8'h00, 8'h00, 1'b0, 32'h00000000, 1'b1, !SHORT_EN};
        vecs[4] = '{1,   8'h33, 8'h33, 1'b0, 32'h33333333, 1'b0, 1'b1};
        vecs[5] = '{255, 8'h01, 8'h01, 1'b0, 32'hAC468F00, 1'b0, 1'b0};
        vecs[6] = '{2,   8'h02, 8'h00, 1'b0, 32'h10080402, 1'b0, 1'b1};
        vecs[7] = '{5,   8'h01, 8'h00, 1'b0, 32'hCD1D1001, 1'b0, !SHORT_EN};

        repeat (3) @(negedge clk);
        checkOutput("rst_syn_val", 64'(syn_val), 64'd0);
        checkOutput("rst_syn", 64'(syn), 64'd0);
        checkOutput("rst_syn_zero", 64'(syn_zero), 64'd0);
        checkOutput("rst_len_err", 64'(len_err), 64'd0);
        checkOutput("rst_ovf", 64'(ovf), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].len, vecs[i].first, vecs[i].last, vecs[i].gap);
            checkOutput($sformatf("v%0d_syn_val", i), 64'(syn_val), 64'd1);
            checkOutput($sformatf("v%0d_syn", i), 64'(syn), 64'(vecs[i].expSyn));
            checkOutput($sformatf("v%0d_syn_zero", i), 64'(syn_zero), 64'(vecs[i].expZero));
            checkOutput($sformatf("v%0d_len_err", i), 64'(len_err), 64'(vecs[i].expLen));
            checkOutput($sformatf("v%0d_ovf", i), 64'(ovf), 64'd0);
            checkOutput($sformatf("v%0d_busy", i), 64'(busy), 64'd0);
            syn_rdy = 1'b1;
            @(negedge clk);
            syn_rdy = 1'b0;
            checkOutput($sformatf("v%0d_accepted", i), 64'(syn_val), 64'd0);
        end

        // Stray eop and sop-less symbols in IDLE produce nothing
        @(negedge clk);
        din_val = 1'b1; din_eop = 1'b1; din = 8'h55;
        @(negedge clk);
        din_eop = 1'b0; din = 8'h66;
        @(negedge clk);
        driveIdle();
        @(negedge clk);
        checkOutput("stray_syn_val", 64'(syn_val), 64'd0);
        checkOutput("stray_busy", 64'(busy), 64'd0);

        // sop inside ACC restarts accumulation
        @(negedge clk);
        din_val = 1'b1; din_sop = 1'b1; din = 8'h77;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            din_sop = 1'b0; din = 8'h12;
        end
        @(negedge clk);
        driveIdle();
        checkOutput("restart_busy", 64'(busy), 64'd1);
        applyStimulus(2, 8'h02, 8'h00, 1'b0);
        checkOutput("restart_syn", 64'(syn), 64'h10080402);
        checkOutput("restart_val", 64'(syn_val), 64'd1);
        syn_rdy = 1'b1;
        @(negedge clk);
        syn_rdy = 1'b0;

        // Back-to-back frames with ready high: no bubble, no overflow
        syn_rdy = 1'b1;
        @(negedge clk);
        din_val = 1'b1; din_sop = 1'b1; din = 8'h02;
        @(negedge clk);
        din_sop = 1'b0; din_eop = 1'b1; din = 8'h00;
        @(negedge clk);
        checkOutput("b2b_first_val", 64'(syn_val), 64'd1);
        checkOutput("b2b_first_syn", 64'(syn), 64'h10080402);
        din_sop = 1'b1; din_eop = 1'b1; din = 8'h33;
        @(negedge clk);
        driveIdle();
        checkOutput("b2b_second_val", 64'(syn_val), 64'd1);
        checkOutput("b2b_second_syn", 64'(syn), 64'h33333333);
        checkOutput("b2b_ovf", 64'(ovf), 64'd0);
        @(negedge clk);
        checkOutput("b2b_drained", 64'(syn_val), 64'd0);
        syn_rdy = 1'b0;

        // Same frames with ready low: second frame overflows
        @(negedge clk);
        din_val = 1'b1; din_sop = 1'b1; din = 8'h02;
        @(negedge clk);
        din_sop = 1'b0; din_eop = 1'b1; din = 8'h00;
        @(negedge clk);
        checkOutput("hold_first_val", 64'(syn_val), 64'd1);
        din_sop = 1'b1; din_eop = 1'b1; din = 8'h33;
        @(negedge clk);
        driveIdle();
        checkOutput("hold_ovf_pulse", 64'(ovf), 64'd1);
        checkOutput("hold_syn", 64'(syn), 64'h10080402);
        checkOutput("hold_val", 64'(syn_val), 64'd1);
        @(negedge clk);
        checkOutput("hold_ovf_clear", 64'(ovf), 64'd0);
        checkOutput("hold_syn_stable", 64'(syn), 64'h10080402);
        syn_rdy = 1'b1;
        @(negedge clk);
        syn_rdy = 1'b0;
        checkOutput("hold_accepted", 64'(syn_val), 64'd0);

        // Reset mid-frame while a set is held
        applyStimulus(1, 8'h33, 8'h33, 1'b0);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            din_val = 1'b1; din_sop = (k == 0); din = (k == 0) ? 8'h01 : 8'h00;
        end
        @(negedge clk);
        driveIdle();
        checkOutput("midrst_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_syn_val", 64'(syn_val), 64'd0);
        checkOutput("midrst_syn", 64'(syn), 64'd0);
        checkOutput("midrst_len_err", 64'(len_err), 64'd0);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(255, 8'h01, 8'h00, 1'b0);
        checkOutput("postrst_val", 64'(syn_val), 64'd1);
        checkOutput("postrst_syn", 64'(syn), 64'hAD478E01);
        checkOutput("postrst_len_err", 64'(len_err), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
